// File: rtl/ahfp_norm_ctrl.sv
// ahfp_norm_ctrl: post-subtract normaliser for the floating-point adder.
// Takes an unnormalised mantissa and its biased exponent. It finds the leading
// one, then shifts the mantissa left by at most STEP bits per cycle until the
// MSB is set. The exponent is reduced by the same count. A zero mantissa and
// an exponent underflow are both reported as flushed-to-zero results.
module ahfp_norm_ctrl #(
  parameter int MW   = 48,
  parameter int EW   = 8,
  parameter int STEP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_uf,
  output logic          busy
);

  // The shift counter must hold any leading-zero count, which is at most MW-1.
  localparam int LW = (MW > 1) ? $clog2(MW) : 1;
  // This width holds both the exponent and the count, so comparing and
  // subtracting them cannot overflow.
  localparam int CW = EW + LW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DETECT = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Priority leading-zero count over all MW bits. For an all-zero input the
  // result is MW-1; callers screen out zero separately.
  function automatic logic [LW-1:0] lzc_f(input logic [MW-1:0] m);
    logic [LW-1:0] c;
    c = LW'(MW - 1);
    for (int i = 0; i < MW; i++) begin
      if (m[i]) begin
        c = LW'(MW - 1 - i);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  logic [1:0]    state_r,     state_nx_s;
  logic [MW-1:0] mant_r,      mant_nx_s;
  logic [EW-1:0] exp_r,       exp_nx_s;
  logic          sign_r,      sign_nx_s;
  logic [LW-1:0] rem_r,       rem_nx_s;
  logic [MW-1:0] out_mant_r,  out_mant_nx_s;
  logic [EW-1:0] out_exp_r,   out_exp_nx_s;
  logic          out_sign_r,  out_sign_nx_s;
  logic          out_zero_r,  out_zero_nx_s;
  logic          out_uf_r,    out_uf_nx_s;
  logic          out_valid_r;
  logic          in_ready_r;
  logic          busy_r;

  logic [LW-1:0] lzc_s;
  logic [CW-1:0] exp_diff_s;
  logic [EW-1:0] exp_adj_s;
  logic          uf_s;
  logic [LW-1:0] amt_s;
  logic [MW-1:0] shifted_s;

  // Leading-zero count, underflow test and the adjusted exponent for DETECT.
  always_comb begin
    lzc_s      = lzc_f(mant_r);
    uf_s       = (CW'(exp_r) <= CW'(lzc_s));
    exp_diff_s = CW'(exp_r) - CW'(lzc_s);
    exp_adj_s  = exp_diff_s[EW-1:0];
  end

  // Shift by this many bits in the current SHIFT cycle: min(remaining, STEP).
  always_comb begin
    amt_s = LW'(STEP);
    if (int'(rem_r) < STEP) begin
      amt_s = rem_r;
    end else begin
      amt_s = LW'(STEP);
    end
    shifted_s = mant_r << amt_s;
  end

  // Next-state and datapath logic for the normalising sequence.
  always_comb begin
    state_nx_s    = state_r;
    mant_nx_s     = mant_r;
    exp_nx_s      = exp_r;
    sign_nx_s     = sign_r;
    rem_nx_s      = rem_r;
    out_mant_nx_s = out_mant_r;
    out_exp_nx_s  = out_exp_r;
    out_sign_nx_s = out_sign_r;
    out_zero_nx_s = out_zero_r;
    out_uf_nx_s   = out_uf_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          mant_nx_s  = in_mant;
          exp_nx_s   = in_exp;
          sign_nx_s  = in_sign;
          state_nx_s = ST_DETECT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DETECT: begin
        if (mant_r == '0) begin
          out_mant_nx_s = '0;
          out_exp_nx_s  = '0;
          out_sign_nx_s = 1'b0;
          out_zero_nx_s = 1'b1;
          out_uf_nx_s   = 1'b0;
          state_nx_s    = ST_DONE;
        end else if (uf_s) begin
          out_mant_nx_s = '0;
          out_exp_nx_s  = '0;
          out_sign_nx_s = 1'b0;
          out_zero_nx_s = 1'b0;
          out_uf_nx_s   = 1'b1;
          state_nx_s    = ST_DONE;
        end else begin
          exp_nx_s = exp_adj_s;
          rem_nx_s = lzc_s;
          if (lzc_s != '0) begin
            state_nx_s = ST_SHIFT;
          end else begin
            // Already normalised: publish the operand unchanged.
            out_mant_nx_s = mant_r;
            out_exp_nx_s  = exp_adj_s;
            out_sign_nx_s = sign_r;
            out_zero_nx_s = 1'b0;
            out_uf_nx_s   = 1'b0;
            state_nx_s    = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        mant_nx_s = shifted_s;
        rem_nx_s  = rem_r - amt_s;
        if (rem_r == amt_s) begin
          out_mant_nx_s = shifted_s;
          out_exp_nx_s  = exp_r;
          out_sign_nx_s = sign_r;
          out_zero_nx_s = 1'b0;
          out_uf_nx_s   = 1'b0;
          state_nx_s    = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Results stay frozen until downstream takes them. The return to
        // IDLE never coincides with an accept because in_ready is low here.
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags; reset drops any operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mant_r      <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      rem_r       <= '0;
      out_mant_r  <= '0;
      out_exp_r   <= '0;
      out_sign_r  <= 1'b0;
      out_zero_r  <= 1'b0;
      out_uf_r    <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      mant_r      <= mant_nx_s;
      exp_r       <= exp_nx_s;
      sign_r      <= sign_nx_s;
      rem_r       <= rem_nx_s;
      out_mant_r  <= out_mant_nx_s;
      out_exp_r   <= out_exp_nx_s;
      out_sign_r  <= out_sign_nx_s;
      out_zero_r  <= out_zero_nx_s;
      out_uf_r    <= out_uf_nx_s;
      out_valid_r <= (state_nx_s == ST_DONE);
      in_ready_r  <= (state_nx_s == ST_IDLE);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_mant  = out_mant_r;
  assign out_exp   = out_exp_r;
  assign out_sign  = out_sign_r;
  assign out_zero  = out_zero_r;
  assign out_uf    = out_uf_r;

endmodule

// File: doc/ahfp_norm_ctrl.md
AHFP_NORM_CTRL -- requirements
Module: ahfp_norm_ctrl

Interface
REQ-001 The block SHALL have parameter MW, default 48, giving the mantissa width in bits.
REQ-002 The block SHALL have parameter EW, default 8, giving the exponent width in bits.
REQ-003 The block SHALL have parameter STEP, default 8, giving the maximum left shift per SHIFT cycle.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-008 The block SHALL have port in_mant, input, MW bits: the unnormalised mantissa (subtractor difference).
REQ-009 The block SHALL have port in_exp, input, EW bits: the biased exponent before normalisation.
REQ-010 The block SHALL have port in_sign, input, 1 bit: the result sign.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port out_mant, output, MW bits: the normalised mantissa, MSB set unless the result is zero.
REQ-014 The block SHALL have port out_exp, output, EW bits: the adjusted exponent.
REQ-015 The block SHALL have port out_sign, output, 1 bit: the result sign.
REQ-016 The block SHALL have port out_zero, output, 1 bit: asserted when the input mantissa was zero.
REQ-017 The block SHALL have port out_uf, output, 1 bit: asserted when the result underflowed and was flushed to zero.
REQ-018 The block SHALL have port busy, output, 1 bit: asserted when the state is not IDLE.

Function
REQ-019 The block SHALL implement the states IDLE, DETECT, SHIFT and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 An accept (in_valid & in_ready) SHALL register in_mant, in_exp and in_sign, and the next state SHALL be DETECT.
REQ-022 in_valid outside IDLE SHALL be ignored, with no effect on state or data.
REQ-023 In DETECT the block SHALL compute lzc, the count of zeros above the highest set bit of the registered mantissa (lzc = MW-1-position), using a priority detect over all MW bits.
REQ-024 In DETECT, if the mantissa is 0, the next state SHALL be DONE with out_mant=0, out_exp=0, out_sign=0, out_zero=1 and out_uf=0.
REQ-025 Otherwise in DETECT, if exp <= lzc (unsigned), the next state SHALL be DONE with out_mant=0, out_exp=0, out_sign=0, out_zero=0 and out_uf=1.
REQ-026 Otherwise in DETECT, the block SHALL set exp := exp - lzc and remaining := lzc; the next state SHALL be SHIFT if lzc > 0, else DONE.
REQ-027 Each SHIFT cycle SHALL left-shift the mantissa by min(remaining, STEP), zero-filling, and decrement remaining by the same amount.
REQ-028 The block SHALL go to DONE when remaining reaches 0.
REQ-029 The number of SHIFT cycles SHALL be ceil(lzc/STEP).
REQ-030 Latency SHALL be: out_valid rises 2 + ceil(lzc/STEP) clock edges after the accept edge; zero and underflow cases SHALL take 2 edges.
REQ-031 In DONE, out_valid SHALL be 1 and all out_* SHALL be held stable until out_ready=1.
REQ-032 DONE with out_ready=1 SHALL return to IDLE on that edge; no new operand SHALL be accepted on that same edge.
REQ-033 out_ready SHALL be ignored outside DONE.
REQ-034 The remaining counter width SHALL be at least ceil(log2(MW)) bits.
REQ-035 The exponent subtract SHALL never wrap, as guaranteed by the underflow check.
REQ-036 out_sign SHALL equal the registered sign for normal results.

Reset
REQ-037 rst=1 at a clock edge SHALL force IDLE from any state, including mid-SHIFT, and discard the in-flight operand.
REQ-038 While rst=1, the outputs SHALL be: out_valid=0, in_ready=0, busy=0, out_mant=0, out_exp=0, out_sign=0, out_zero=0, out_uf=0.
REQ-039 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-040 The bench SHALL cover: in_mant=48'h800000000000, in_exp=100 -> after 2 edges out_valid=1, out_mant unchanged, out_exp=100.
REQ-041 The bench SHALL cover: in_mant=48'h000000100000 (lzc=27), in_exp=100 -> 4 SHIFT cycles (8,8,8,3), out_valid after 6 edges, out_mant=48'h800000000000, out_exp=73.
REQ-042 The bench SHALL cover: in_mant=0, in_sign=1 -> after 2 edges out_zero=1, out_mant=0, out_exp=0, out_sign=0.
REQ-043 The bench SHALL cover: in_mant=48'h1 (lzc=47), in_exp=47 -> out_uf=1, out_mant=0, out_exp=0; the same mantissa with in_exp=48 -> out_exp=1, out_mant MSB set, 6 SHIFT cycles.
REQ-044 The bench SHALL cover: out_ready held 0 for 3 cycles in DONE -> outputs stable and in_ready=0; in_valid pulses during busy do not change the result.
REQ-045 The bench SHALL cover: rst asserted during the second SHIFT cycle -> the next cycle shows IDLE, out_valid=0, and in_ready=1 after release; the following operand is processed correctly.
